// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and flag indices for the shared-ALU scheduler
package alu_share_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } ctrl_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - team 2-bit-op ALU (ADD/SUB/AND/OR); NZCV flags when ALU_FLAGS_EN is defined
module alu
    import alu_share_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]        flags
`endif
);

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] sum;

    // SUB is a + ~b + 1 so the carry out is the ARM-style NOT borrow.
    always_comb begin
        sum   = '0;
        flags = '0;
        case (op)
            ALU_ADD: sum = {1'b0, a} + {1'b0, b};
            ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
            ALU_AND: sum = {1'b0, a & b};
            default: sum = {1'b0, a | b};
        endcase
        result        = sum[DATA_W-1:0];
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_Z] = (result == '0);
        case (op)
            ALU_ADD: begin
                flags[FLAG_C] = sum[DATA_W];
                flags[FLAG_V] = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                flags[FLAG_C] = sum[DATA_W];
                flags[FLAG_V] = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            default: begin
                flags[FLAG_C] = 1'b0;
                flags[FLAG_V] = 1'b0;
            end
        endcase
    end
`else
    always_comb begin
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
    end
`endif

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant starting at ptr
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic              found;
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   idx;

    // Walk the requesters from ptr upward, wrapping at NUM_REQ; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin scheduler sharing one ALU among NUM_REQ requesters
// Optional resp_flags output when ALU_FLAGS_EN is defined.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*2-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
`ifdef ALU_FLAGS_EN
    output logic [3:0]                resp_flags,
`endif
    output logic                      busy
);

    ctrl_state_t       state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    alu_op_t           op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0] grant;
    logic [DATA_W-1:0] alu_result;
`ifdef ALU_FLAGS_EN
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        alu_flags;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
`ifdef ALU_FLAGS_EN
        ,
        .flags  (alu_flags)
`endif
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
`ifdef ALU_FLAGS_EN
        flags_d     = flags_q;
`endif
        req_ready   = '0;
        resp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        op_d = alu_op_t'(req_op[2*i +: 2]);
                        a_d  = req_a[DATA_W*i +: DATA_W];
                        b_d  = req_b[DATA_W*i +: DATA_W];
                        id_d = ID_W'(i);
                    end
                end
                if (|grant) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d = alu_result;
`ifdef ALU_FLAGS_EN
                flags_d     = alu_flags;
`endif
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    // Next search starts just past the requester we served.
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= ALU_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            resp_data_q <= '0;
`ifdef ALU_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            resp_data_q <= resp_data_d;
`ifdef ALU_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign resp_data = resp_data_q;
    assign resp_id   = id_q;
    assign busy      = (state_q != IDLE);
`ifdef ALU_FLAGS_EN
    assign resp_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed and random self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*2-1:0]      req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic [ID_W-1:0]           resp_id;
    logic                      busy;
`ifdef ALU_FLAGS_EN
    logic [3:0]                resp_flags;
`endif

    alu_op_t           op_arr [NUM_REQ];
    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];

    int n_assert = 0;
    int n_fail   = 0;
    int mptr     = 0;

    logic              hold_v = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [ID_W-1:0]   hold_id;

    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[2*i +: 2]      = op_arr[i];
            req_a[DATA_W*i +: DATA_W] = a_arr[i];
            req_b[DATA_W*i +: DATA_W] = b_arr[i];
        end
    end

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
`ifdef ALU_FLAGS_EN
        .resp_flags (resp_flags),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor, sampled late in the low phase so values match the next rising edge.
    always @(negedge clk) begin
        #3;
        n_assert++;
        assert ($onehot0(req_ready)) else begin
            n_fail++;
            $error("FAIL req_ready_onehot: observed %b expected one-hot-or-zero", req_ready);
        end
        if (hold_v && resp_valid) begin
            n_assert++;
            assert (resp_data === hold_data && resp_id === hold_id) else begin
                n_fail++;
                $error("FAIL resp_stable: observed %0h/%0d expected %0h/%0d", resp_data, resp_id, hold_data, hold_id);
            end
        end
        hold_v    = resp_valid && !resp_ready && !rst;
        hold_data = resp_data;
        hold_id   = resp_id;
    end

    function automatic logic [DATA_W-1:0] m_alu(input alu_op_t op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] m_flags(input alu_op_t op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        longint sr;
        logic c, v;
        r = m_alu(op, a, b);
        c = 1'b0;
        v = 1'b0;
        if (op == ALU_ADD) begin
            c  = ((64'(a) + 64'(b)) >> DATA_W) != 0;
            sr = longint'($signed(a)) + longint'($signed(b));
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else if (op == ALU_SUB) begin
            c  = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        return {r[DATA_W-1], (r == '0), c, v};
    endfunction

    function automatic int m_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // One full operation: grant in IDLE, EXEC, then RESP held for `stall` extra cycles.
    task automatic op_cycle(input string tag, input logic [NUM_REQ-1:0] valid, input int gidx,
                            input alu_op_t op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [DATA_W-1:0] exp_data, input logic [3:0] exp_flags, input int stall);
        logic [NUM_REQ-1:0] exp_gnt;
        exp_gnt = NUM_REQ'(1) << gidx;
        @(negedge clk);
        op_arr[gidx] = op;
        a_arr[gidx]  = a;
        b_arr[gidx]  = b;
        req_valid    = valid;
        resp_ready   = (stall == 0);
        #1;
        chk({tag, "_grant"}, 64'(req_ready), 64'(exp_gnt));
        @(negedge clk);
        #1;
        chk({tag, "_exec_busy"}, 64'(busy), 64'd1);
        chk({tag, "_exec_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_exec_rvalid"}, 64'(resp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({tag, "_rvalid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_data"}, 64'(resp_data), 64'(exp_data));
        chk({tag, "_id"}, 64'(resp_id), 64'(gidx));
`ifdef ALU_FLAGS_EN
        chk({tag, "_flags"}, 64'(resp_flags), 64'(exp_flags));
`endif
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "_stall_rvalid"}, 64'(resp_valid), 64'd1);
            chk({tag, "_stall_ready"}, 64'(req_ready), 64'd0);
            chk({tag, "_stall_data"}, 64'(resp_data), 64'(exp_data));
        end
        resp_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] rv;
        int g;
        alu_op_t rop;
        logic [DATA_W-1:0] ra, rb;

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_arr[i] = ALU_ADD;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rvalid", 64'(resp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_data", 64'(resp_data), 64'd0);
        chk("reset_id", 64'(resp_id), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd0);
`ifdef ALU_FLAGS_EN
        chk("reset_flags", 64'(resp_flags), 64'd0);
`endif
        rst = 1'b0;

        // Single ops, including wrap and overflow corners.
        op_cycle("add_basic", 4'b0001, 0, ALU_ADD, 32'd5, 32'd7, 32'd12, 4'b0000, 0);
        op_cycle("sub_neg", 4'b0010, 1, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 0);
        op_cycle("add_ovf", 4'b0100, 2, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 0);
        op_cycle("add_carry", 4'b1000, 3, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 0);

        // All requesters valid: strict rotation 0,1,2,3,0.
        op_cycle("rr0", 4'b1111, 0, ALU_ADD, 32'd10, 32'd20, 32'd30, 4'b0000, 0);
        op_cycle("rr1", 4'b1111, 1, ALU_SUB, 32'd100, 32'd1, 32'd99, 4'b0010, 0);
        op_cycle("rr2", 4'b1111, 2, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 0);
        op_cycle("rr3", 4'b1111, 3, ALU_OR, 32'h0F, 32'hF0, 32'hFF, 4'b0000, 0);
        op_cycle("rr4", 4'b1111, 0, ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 0);

        // Back-pressure for 5 cycles, then the next grant follows.
        op_cycle("stall", 4'b1111, 1, ALU_AND, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 4'b0000, 5);
        op_cycle("after_stall", 4'b1111, 2, ALU_OR, 32'd0, 32'd0, 32'd0, 4'b0100, 0);

        // Reset mid-operation: pointer was 3, so a post-reset grant to 0 proves rr_ptr cleared.
        @(negedge clk);
        req_valid = 4'b0001;
        op_arr[0] = ALU_ADD;
        a_arr[0]  = 32'd9;
        b_arr[0]  = 32'd9;
        #1;
        chk("rst_pre_grant", 64'(req_ready), 64'b0001);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("rst_exec_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("rst_rvalid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(resp_data), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_no_resp", 64'(resp_valid), 64'd0);
        op_cycle("post_rst", 4'b1001, 0, ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, 0);
        mptr = 1;

        // Random traffic against the reference model.
        for (int n = 0; n < 24; n++) begin
            rv  = NUM_REQ'($urandom_range(1, 15));
            g   = m_grant(rv, mptr);
            rop = alu_op_t'(2'($urandom_range(0, 3)));
            ra  = $urandom;
            rb  = $urandom;
            if (n % 6 == 0) rb = ra;
            op_cycle("rand", rv, g, rop, ra, rb, m_alu(rop, ra, rb), m_flags(rop, ra, rb), int'($urandom_range(0, 2)));
            mptr = (g + 1) % NUM_REQ;
        end

        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
